dac_spi_driver: RTL and testbench

DAC_SPI_DRIVER -- requirements
Module: dac_spi_driver

---
 rtl/dac_spi_pkg.sv | 21 ++
 rtl/dac_sclk_gen.sv | 33 +++
 rtl/dac_spi_driver.sv | 116 +++++++++++
 tb/tb_dac_spi_driver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types and constants for the DAC SPI driver.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    LATCH
  } state_t;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;
  localparam int         FRAME_BITS       = 16;
  localparam int         DATA_BITS        = 12;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic                 power_down,
                                                        input logic [DATA_BITS-1:0] code);
    return power_down ? {CMD_POWER_DOWN, DATA_BITS'(0)} : {CMD_WRITE_UPDATE, code};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// Half-period timebase: tick on the last cycle of every CLK_DIV-cycle window.
module dac_sclk_gen
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] CNT_PRE  = 8'(CLK_DIV - 2);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || restart || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick     = en && (cnt == CNT_LAST);
  assign pre_tick = en && (cnt == CNT_PRE);

endmodule

// File: rtl/dac_spi_driver.sv
// 16-bit SPI frame driver for a DAC: write/update or power-down, then LDAC strobe.
module dac_spi_driver
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int DAC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DAC_WIDTH-1:0] dac_code,
  input  logic                 no_order,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  output logic                 ldac_n,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [4:0] HALF_LAST = 5'(2 * FRAME_BITS - 1);

  state_t                 state, nstate;
  logic [DAC_WIDTH-1:0]   last_code;
  logic                   last_mode;
  logic                   pending;
  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  frame_in;
  logic [DATA_BITS-1:0]   code_data;
  logic [4:0]             half_cnt;
  logic                   tick, pre_tick;
  logic                   start, restart, last_half;

  assign code_data = DATA_BITS'(dac_code);
  assign frame_in  = build_frame(no_order, code_data);
  assign start     = (state == IDLE) &&
                     (pending || (dac_code != last_code) || (no_order != last_mode));
  assign last_half = (half_cnt == HALF_LAST);
  assign restart   = (nstate != state);

  dac_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state != IDLE),
    .restart (restart),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start)              nstate = SETUP;
      SETUP:   if (tick)               nstate = SHIFT;
      SHIFT:   if (tick && last_half)  nstate = LATCH;
      LATCH:   if (tick)               nstate = IDLE;
      default:                         nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_code <= '0;
      last_mode <= 1'b1;
      pending   <= 1'b1;
    end else if (start) begin
      last_code <= dac_code;
      last_mode <= no_order;
      pending   <= 1'b0;
    end
  end

  // Outputs are registered from next-state, so they line up with the state
  // they describe; frame_done is set one cycle early from pre_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      ldac_n     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      half_cnt   <= '0;
    end else begin
      cs_n       <= !((nstate == SETUP) || (nstate == SHIFT));
      ldac_n     <= (nstate != LATCH);
      busy       <= (nstate != IDLE);
      frame_done <= (state == LATCH) && pre_tick;
      if (start) begin
        shreg    <= frame_in;
        mosi     <= frame_in[FRAME_BITS-1];
        sclk     <= 1'b0;
        half_cnt <= '0;
      end else if ((state == SHIFT) && tick && !last_half) begin
        half_cnt <= half_cnt + 5'd1;
        sclk     <= ~sclk;
        if (sclk) begin
          shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
          mosi  <= shreg[FRAME_BITS-2];
        end
      end else if ((nstate != SETUP) && (nstate != SHIFT)) begin
        sclk     <= 1'b0;
        mosi     <= 1'b0;
        half_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_driver.sv
// Directed bench for dac_spi_driver at CLK_DIV=4 (dut index 0) and CLK_DIV=2 (dut index 1).
module tb_dac_spi_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] code [2];
  logic        nord [2];
  logic        sclk_w [2];
  logic        cs_n_w [2];
  logic        mosi_w [2];
  logic        ldac_w [2];
  logic        busy_w [2];
  logic        done_w [2];

  always #5 clk = ~clk;

  dac_spi_driver #(.CLK_DIV(4), .DAC_WIDTH(12)) dut0 (
    .clk(clk), .rst(rst), .dac_code(code[0]), .no_order(nord[0]),
    .sclk(sclk_w[0]), .cs_n(cs_n_w[0]), .mosi(mosi_w[0]),
    .ldac_n(ldac_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

  dac_spi_driver #(.CLK_DIV(2), .DAC_WIDTH(12)) dut1 (
    .clk(clk), .rst(rst), .dac_code(code[1]), .no_order(nord[1]),
    .sclk(sclk_w[1]), .cs_n(cs_n_w[1]), .mosi(mosi_w[1]),
    .ldac_n(ldac_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

  typedef struct {
    int          phase;   // 0 = idle, else cycle 1..34*div within the frame
    logic [15:0] frame;
    logic [11:0] last_code;
    logic        last_mode;
    logic        pending;
  } mdl_t;

  mdl_t        m [2];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        prev_sclk [2];
  logic        prev_csn [2];
  logic [15:0] rx [2];
  logic [15:0] word [2];
  int          falls [2], dones [2], busy_n [2], ldac_cnt [2];
  int          start_cyc [2], done_cyc [2], rise_prev [2], sclk_per [2];
  int          last_busy [2], last_ldac [2];

  function automatic int div_of(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // {sclk, cs_n, mosi, ldac_n, busy, frame_done} from the frame timeline
  function automatic logic [5:0] expect_out(int d, int p, logic [15:0] f);
    int h;
    if (p == 0) return 6'b010100;
    if (p <= d) return {1'b0, 1'b0, f[15], 3'b110};
    if (p <= 33 * d) begin
      h = (p - d - 1) / d;
      return {h[0], 1'b0, f[15 - h / 2], 3'b110};
    end
    return {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, (p == 34 * d)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].phase     = 0;
      m[i].frame     = '0;
      m[i].last_code = '0;
      m[i].last_mode = 1'b1;
      m[i].pending   = 1'b1;
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m[i].phase == 0) begin
          if (m[i].pending || code[i] != m[i].last_code || nord[i] != m[i].last_mode) begin
            m[i].frame     = nord[i] ? 16'h4000 : {4'h3, code[i]};
            m[i].last_code = code[i];
            m[i].last_mode = nord[i];
            m[i].pending   = 1'b0;
            m[i].phase     = 1;
          end
        end else if (m[i].phase == 34 * div_of(i)) begin
          m[i].phase = 0;
        end else begin
          m[i].phase++;
        end
      end
    end
  endtask

  task automatic check_cycle();
    logic [5:0] act;
    for (int i = 0; i < 2; i++) begin
      act = {sclk_w[i], cs_n_w[i], mosi_w[i], ldac_w[i], busy_w[i], done_w[i]};
      check($sformatf("cyc%0d_dut%0d_outputs", cyc, i), 32'(act),
            32'(expect_out(div_of(i), m[i].phase, m[i].frame)));
      if (prev_csn[i] && !cs_n_w[i]) begin
        falls[i]++;
        start_cyc[i] = cyc;
        busy_n[i]    = 0;
        ldac_cnt[i]  = 0;
        rise_prev[i] = -1;
      end
      if (busy_w[i]) busy_n[i]++;
      if (!ldac_w[i]) ldac_cnt[i]++;
      if (!prev_sclk[i] && sclk_w[i]) begin
        rx[i] = {rx[i][14:0], mosi_w[i]};
        if (rise_prev[i] >= 0) sclk_per[i] = cyc - rise_prev[i];
        rise_prev[i] = cyc;
      end
      if (done_w[i]) begin
        dones[i]++;
        word[i]      = rx[i];
        done_cyc[i]  = cyc;
        last_busy[i] = busy_n[i];
        last_ldac[i] = ldac_cnt[i];
      end
      prev_sclk[i] = sclk_w[i];
      prev_csn[i]  = cs_n_w[i];
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_clock();
    cyc++;
    #2;
  endtask

  task automatic wait_done(int i, int budget, string name);
    int d0 = dones[i];
    int n  = 0;
    while (dones[i] == d0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_done_seen"}, 32'(dones[i] != d0), 32'd1);
  endtask

  task automatic wait_start(int i, int budget, string name);
    int f0 = falls[i];
    int n  = 0;
    while (falls[i] == f0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_start_seen"}, 32'(falls[i] != f0), 32'd1);
  endtask

  initial begin
    int f0, d0, dc;
    for (int i = 0; i < 2; i++) begin
      prev_sclk[i] = 1'b0; prev_csn[i] = 1'b1; rx[i] = '0; word[i] = '0;
      falls[i] = 0; dones[i] = 0; busy_n[i] = 0; ldac_cnt[i] = 0;
      start_cyc[i] = 0; done_cyc[i] = 0; rise_prev[i] = -1; sclk_per[i] = 0;
      last_busy[i] = 0; last_ldac[i] = 0;
    end
    model_reset();
    rst     = 1'b1;
    nord[0] = 1'b1; code[0] = 12'h000;
    nord[1] = 1'b0; code[1] = 12'hFFF;
    @(posedge clk); #2;
    repeat (3) step();
    #1;
    check("reset_dut0", 32'({sclk_w[0], cs_n_w[0], mosi_w[0], ldac_w[0], busy_w[0], done_w[0]}), 32'h14);
    check("reset_dut1", 32'({sclk_w[1], cs_n_w[1], mosi_w[1], ldac_w[1], busy_w[1], done_w[1]}), 32'h14);
    rst = 1'b0;

    // power-down frame after release, alongside the CLK_DIV=2 write of 0xFFF
    wait_done(0, 300, "pd");
    check("pd_word", 32'(word[0]), 32'h4000);
    check("pd_length", 32'(done_cyc[0] - start_cyc[0] + 1), 32'd136);
    check("div2_word", 32'(word[1]), 32'h3FFF);
    check("div2_length", 32'(done_cyc[1] - start_cyc[1] + 1), 32'd68);
    check("div2_sclk_period", 32'(sclk_per[1]), 32'd4);
    check("div2_busy", 32'(last_busy[1]), 32'd68);
    f0 = falls[0];
    repeat (60) step();
    check("pd_idle_after", 32'(falls[0]), 32'(f0));

    // write 0x0A5
    nord[0] = 1'b0; code[0] = 12'h0A5;
    wait_done(0, 300, "w0a5");
    check("w0a5_word", 32'(word[0]), 32'h30A5);
    check("w0a5_ldac_cycles", 32'(last_ldac[0]), 32'd4);
    check("w0a5_busy_cycles", 32'(last_busy[0]), 32'd136);
    repeat (5) step();

    // change mid-frame is held off until the frame ends
    code[0] = 12'h100;
    wait_start(0, 20, "w100");
    repeat (19) step();
    code[0] = 12'h200;
    wait_done(0, 300, "w100");
    check("w100_word", 32'(word[0]), 32'h3100);
    dc = done_cyc[0];
    wait_start(0, 20, "w200");
    check("w200_start_gap", 32'(start_cyc[0] - dc), 32'd2);
    wait_done(0, 300, "w200");
    check("w200_word", 32'(word[0]), 32'h3200);

    // steady code: exactly one frame, then silence
    code[0] = 12'h7FF;
    f0 = falls[0];
    wait_done(0, 300, "w7ff");
    check("w7ff_word", 32'(word[0]), 32'h37FF);
    repeat (1000) step();
    check("w7ff_single_frame", 32'(falls[0] - f0), 32'd1);

    // reset in the middle of a frame
    code[0] = 12'h123;
    wait_start(0, 20, "abort");
    repeat (49) step();
    d0  = dones[0];
    rst = 1'b1;
    model_reset();
    #1;
    check("abort_sclk_csn_ldac", 32'({sclk_w[0], cs_n_w[0], ldac_w[0]}), 32'b011);
    repeat (4) step();
    check("abort_no_done", 32'(dones[0]), 32'(d0));
    rst = 1'b0;
    wait_done(0, 300, "refresh");
    check("refresh_word", 32'(word[0]), 32'h3123);
    check("refresh_length", 32'(done_cyc[0] - start_cyc[0] + 1), 32'd136);
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
